writeback_arbiter: RTL

Write-side front end for the 32x32 register file: merges ALU results and load completions onto the register file's single write port. Issues at most one write per cycle, with load priority. Buffers displaced ALU results in a small in-order queue. Suppresses x0 writes and squashes stale queued ALU writes overtaken by a younger load to the same register. Sits between the execute/memory stages and the register file's write port (`regWrite`/`rd`/`writeData`).

---
 rtl/rf_pkg.sv | 19 +
 rtl/writeback_arbiter_if.sv | 34 +++
 rtl/wb_squash_fifo.sv | 84 ++++++++
 rtl/writeback_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
//------------------------------------------------------------------------------
// rf_pkg : register-file constants and the write-back entry type
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rf_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  squashed;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
//------------------------------------------------------------------------------
// writeback_arbiter_if : ALU / load inputs and register-file write port bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface writeback_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  logic                          aluValid;
  logic [rf_pkg::REG_ADDR_W-1:0] aluRd;
  logic [XLEN-1:0]               aluData;
  logic                          aluReady;
  logic                          loadValid;
  logic [rf_pkg::REG_ADDR_W-1:0] loadRd;
  logic [XLEN-1:0]               loadData;
  logic                          regWrite;
  logic [rf_pkg::REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]               writeData;
  logic [$clog2(DEPTH):0]        pendingCount;

  modport master (
    output aluValid, aluRd, aluData, loadValid, loadRd, loadData,
    input  aluReady, regWrite, rd, writeData, pendingCount
  );

  modport slave (
    input  aluValid, aluRd, aluData, loadValid, loadRd, loadData,
    output aluReady, regWrite, rd, writeData, pendingCount
  );
endinterface

`default_nettype wire

// File: rtl/wb_squash_fifo.sv
//------------------------------------------------------------------------------
// wb_squash_fifo : in-order circular queue of ALU results with per-entry squash
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_squash_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_push,
  input  wire logic [REG_ADDR_W-1:0] i_push_rd,
  input  wire logic [XLEN-1:0]       i_push_data,
  input  wire logic                  i_pop,
  input  wire logic                  i_squash_en,
  input  wire logic [REG_ADDR_W-1:0] i_squash_rd,
  output logic                       o_head_sq,
  output logic [REG_ADDR_W-1:0]      o_head_rd,
  output logic [XLEN-1:0]            o_head_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_sq;
  logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign w_push_ok = i_push && (r_count != c_full);
  assign w_pop_ok  = i_pop && (r_count != '0);

  // Pointers are PW bits wide, so wrap modulo DEPTH falls out of the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_sq     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_squash_en && r_valid[i] && (r_rd[i] == i_squash_rd))
          r_sq[i] <= 1'b1;
      end
      if (w_pop_ok) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_sq[r_wr_ptr]    <= 1'b0;
        r_rd[r_wr_ptr]    <= i_push_rd;
        r_data[r_wr_ptr]  <= i_push_data;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  assign o_head_sq   = r_sq[r_rd_ptr];
  assign o_head_rd   = r_rd[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
//------------------------------------------------------------------------------
// writeback_arbiter : load-priority merge of ALU results and loads onto one RF write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  writeback_arbiter_if.slave bus
);
  import rf_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic                  w_head_sq;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]       w_head_data;
  logic [CW-1:0]         w_count;
  logic                  w_alu_ready;
  logic                  w_load_sel;
  logic                  w_alu_fresh;
  logic                  w_deq;
  logic                  w_bypass;
  logic                  w_enq;
  logic                  w_sel_any;
  logic                  w_wr_en;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;

  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wdata;

  assign w_alu_ready = (w_count != c_full);
  assign w_load_sel  = bus.loadValid && (bus.loadRd != REG_ZERO);
  assign w_alu_fresh = bus.aluValid && w_alu_ready && (bus.aluRd != REG_ZERO);
  assign w_deq       = !w_load_sel && (w_count != '0);
  assign w_bypass    = !w_load_sel && (w_count == '0) && w_alu_fresh;
  assign w_enq       = w_alu_fresh && !w_bypass;

  wb_squash_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_enq),
    .i_push_rd   (bus.aluRd),
    .i_push_data (bus.aluData),
    .i_pop       (w_deq),
    .i_squash_en (w_load_sel),
    .i_squash_rd (bus.loadRd),
    .o_head_sq   (w_head_sq),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count)
  );

  // A squashed head still consumes its slot, it just writes nothing.
  always_comb begin
    w_sel_any  = 1'b0;
    w_wr_en    = 1'b0;
    w_sel_rd   = r_rd;
    w_sel_data = r_wdata;
    if (w_load_sel) begin
      w_sel_any  = 1'b1;
      w_wr_en    = 1'b1;
      w_sel_rd   = bus.loadRd;
      w_sel_data = bus.loadData;
    end else if (w_deq) begin
      w_sel_any  = 1'b1;
      w_wr_en    = !w_head_sq;
      w_sel_rd   = w_head_rd;
      w_sel_data = w_head_data;
    end else if (w_bypass) begin
      w_sel_any  = 1'b1;
      w_wr_en    = 1'b1;
      w_sel_rd   = bus.aluRd;
      w_sel_data = bus.aluData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wdata     <= '0;
    end else begin
      r_reg_write <= w_wr_en;
      if (w_sel_any) begin
        r_rd    <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign bus.aluReady     = w_alu_ready;
  assign bus.regWrite     = r_reg_write;
  assign bus.rd           = r_rd;
  assign bus.writeData    = r_wdata;
  assign bus.pendingCount = w_count;

endmodule

`default_nettype wire
